// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Round-robin arbiter sharing one byte-wide memory port between
//               an instruction-fetch requester (0, read-only) and a data
//               load/store requester (1). Each granted word access is run as
//               four sequential byte beats; read bytes are assembled
//               little-endian. Handshake at T -> resp_valid at T+6.
//               Optional performance counters under MEM_ARB_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [1:0]        req_we,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [31:0]       req_wdata1,
    output logic [1:0]        resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    input  logic              perf_clr,
    output logic [31:0]       perf_grant0,
    output logic [31:0]       perf_grant1,
    output logic [31:0]       perf_conflict
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BEAT  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_id;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [31:0]        r_wdata;
    logic [1:0]         r_beat;
    logic               r_last;
    logic [23:0]        r_shift;
    logic [31:0]        r_rdata;

    logic [1:0]         w_gnt;
    logic               w_hs;
    logic               w_hs_id;
    logic [7:0]         w_wbyte;

    // Round-robin grant: a lone requester wins; on conflict the one not served last wins
    always_comb begin
        w_gnt = 2'b00;
        case (req_valid)
            2'b01:   w_gnt = 2'b01;
            2'b10:   w_gnt = 2'b10;
            2'b11:   w_gnt = r_last ? 2'b01 : 2'b10;
            default: w_gnt = 2'b00;
        endcase
    end

    assign req_ready = (r_state == S_IDLE) ? w_gnt : 2'b00;
    assign w_hs      = |(req_valid & req_ready);
    assign w_hs_id   = req_ready[1];

    // Byte lane of the latched store word for the current beat
    always_comb begin
        w_wbyte = 8'h00;
        case (r_beat)
            2'd0:    w_wbyte = r_wdata[7:0];
            2'd1:    w_wbyte = r_wdata[15:8];
            2'd2:    w_wbyte = r_wdata[23:16];
            default: w_wbyte = r_wdata[31:24];
        endcase
    end

    // Next-state and memory/response outputs decoded from the current state
    always_comb begin
        w_state_nxt = r_state;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = 8'h00;
        resp_valid  = 2'b00;
        case (r_state)
            S_IDLE: begin
                if (w_hs) begin
                    w_state_nxt = S_BEAT;
                end
            end
            S_BEAT: begin
                mem_en    = 1'b1;
                mem_we    = r_we;
                mem_addr  = r_addr + {{(ADDR_W-2){1'b0}}, r_beat};
                mem_wdata = w_wbyte;
                if (r_beat == 2'd3) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_state_nxt = S_DONE;
            end
            default: begin
                resp_valid  = r_id ? 2'b10 : 2'b01;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign resp_rdata = r_rdata;

    // State register plus request latch, beat counter and read-byte capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_id    <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= 32'h0;
            r_beat  <= 2'd0;
            r_last  <= 1'b1;
            r_shift <= 24'h0;
            r_rdata <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && w_hs) begin
                r_id    <= w_hs_id;
                // requester 0 is read-only, so its write-enable bit is masked
                r_we    <= req_we[w_hs_id] & w_hs_id;
                r_addr  <= w_hs_id ? req_addr1 : req_addr0;
                r_wdata <= w_hs_id ? req_wdata1 : 32'h0;
                r_last  <= w_hs_id;
                r_beat  <= 2'd0;
            end
            if (r_state == S_BEAT) begin
                r_beat <= r_beat + 2'd1;
                // read data trails the strobe by one cycle: capture from beat 1 on
                if (r_beat != 2'd0) begin
                    r_shift <= {mem_rdata, r_shift[23:8]};
                end
            end
            if (r_state == S_DRAIN) begin
                r_rdata <= r_we ? 32'h0 : {mem_rdata, r_shift};
            end
        end
    end

`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] r_perf_g0;
    logic [31:0] r_perf_g1;
    logic [31:0] r_perf_cf;

    // Saturating grant/conflict counters; a clear overrides a same-cycle increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_g0 <= 32'h0;
            r_perf_g1 <= 32'h0;
            r_perf_cf <= 32'h0;
        end else if (perf_clr) begin
            r_perf_g0 <= 32'h0;
            r_perf_g1 <= 32'h0;
            r_perf_cf <= 32'h0;
        end else if (w_hs) begin
            if (!w_hs_id && r_perf_g0 != 32'hFFFF_FFFF) begin
                r_perf_g0 <= r_perf_g0 + 32'd1;
            end
            if (w_hs_id && r_perf_g1 != 32'hFFFF_FFFF) begin
                r_perf_g1 <= r_perf_g1 + 32'd1;
            end
            if ((&req_valid) && r_perf_cf != 32'hFFFF_FFFF) begin
                r_perf_cf <= r_perf_cf + 32'd1;
            end
        end
    end

    assign perf_grant0   = r_perf_g0;
    assign perf_grant1   = r_perf_g1;
    assign perf_conflict = r_perf_cf;
`endif

endmodule
`default_nettype wire
